// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    // Encoding of the RISC-V wfi instruction. Fetch halts after pushing it,
    // and it is also pushed in place of any out-of-range fetch.
    localparam logic [31:0] WFI = 32'h10500073;

    // Canonical no-op (addi x0,x0,0).
    localparam logic [31:0] NOP = 32'h00000013;

    // Width of one prefetch entry: {pc, instr}.
    localparam int ENTRY_W = 64;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous prefetch FIFO. The head entry is visible without popping.
// A flush empties the FIFO and takes priority over push and pop.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 64,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [W-1:0]  head_data,
    output logic [CW-1:0] count,
    output logic          empty
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    // Qualify push/pop and compute next pointers and occupancy.
    always_comb begin
        do_pop   = pop & ~empty & ~flush;
        do_push  = push & (~full | do_pop) & ~flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state: pointers and occupancy, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage: data only, never reset; validity comes from count.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: drives the instruction ROM, buffers {pc, instr}
// pairs in a prefetch FIFO and hands them to decode over valid/ready.
// Fetch stops after a wfi is pushed; a redirect flushes and restarts it.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int L     = 32,
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(L)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [AW-1:0] imem_addr,
    output logic          imem_oe,
    input  logic [31:0]   imem_data,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_instr,
    output logic [31:0]   out_pc,
    output logic          halted
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_t  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic          in_range;
    logic          fetch_en;
    logic          pop;
    logic [31:0]   push_instr;
    fetch_entry_t  push_entry;
    fetch_entry_t  head_entry;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;

    assign in_range   = (pc_q[31:AW+2] == '0);
    assign imem_addr  = pc_q[AW+1:2];
    assign out_valid  = ~fifo_empty;
    assign pop        = out_valid & out_ready;
    assign out_pc     = head_entry.pc;
    assign out_instr  = head_entry.instr;
    assign halted     = (state_q == HALT);

    // Fetch decision, ROM enable and the entry to push this cycle.
    always_comb begin
        fetch_en   = rst_n & (state_q == RUN) & ~redirect_valid
                   & ((fifo_count < CW'(DEPTH)) | pop);
        imem_oe    = fetch_en & in_range;
        push_instr = in_range ? imem_data : WFI;
        push_entry = '{pc: pc_q, instr: push_instr};
    end

    // Next PC and FSM state; redirect overrides fetch.
    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        if (redirect_valid) begin
            pc_d    = {redirect_pc[31:2], 2'b00};
            state_d = RUN;
        end else if (fetch_en) begin
            pc_d = pc_q + 32'd4;
            if (push_instr == WFI) state_d = HALT;
        end
    end

    // PC and FSM state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= '0;
            state_q <= RUN;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fetch_en),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .head_data (head_entry),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: the stimulus pushes the expected
// {pc, instr} stream, a monitor compares every accepted head entry.
module tb_instr_fetch;
    import fetch_pkg::*;

    localparam int L     = 32;
    localparam int DEPTH = 2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [4:0]  imem_addr;
    logic        imem_oe;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        halted;

    logic [31:0] rom [L];
    exp_t        exp_q [$];
    int          checks;
    int          errors;

    assign imem_data = rom[imem_addr];

    instr_fetch #(.L(L), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_oe        (imem_oe),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rom_word(input logic [31:0] pc);
        logic [4:0] idx;
        idx = pc[6:2];
        return (pc < 32'h80) ? rom[idx] : WFI;
    endfunction

    task automatic expect_range(input logic [31:0] from, input logic [31:0] to);
        for (logic [31:0] p = from; p <= to; p += 32'd4) begin
            exp_t e;
            e.pc    = p;
            e.instr = rom_word(p);
            exp_q.push_back(e);
        end
    endtask

    // Start of a cycle: just after the rising edge, where inputs change.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Mid-cycle sampling point.
    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            cyc();
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop got pc=%h instr=%h want none", out_pc, out_instr);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_pc", out_pc, e.pc);
                    check("out_instr", out_instr, e.instr);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rom[0] = 32'h000000B3;
        rom[1] = NOP;
        rom[2] = 32'h00100093;
        rom[3] = 32'h00208133;
        rom[4] = 32'h402081B3;
        rom[5] = 32'h0020F233;
        rom[6] = 32'h0020E2B3;
        rom[7] = 32'hFE000EE3;
        for (int i = 8; i < L; i++) rom[i] = WFI;

        rst_n          = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        fork
            monitor();
        join_none

        // Free-running stream from reset until the wfi at 0x20.
        out_ready = 1'b1;
        cyc();
        at_neg();
        check("oe_in_reset", 32'(imem_oe), 32'd0);
        check("valid_after_reset", 32'(out_valid), 32'd0);
        check("halted_after_reset", 32'(halted), 32'd0);
        cyc();
        rst_n = 1'b1;
        expect_range(32'h0, 32'h20);
        at_neg();
        check("first_fetch_oe", 32'(imem_oe), 32'd1);
        check("first_fetch_addr", 32'(imem_addr), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            cyc();
            at_neg();
            check("stream_oe", 32'(imem_oe), 32'd1);
            check("stream_addr", 32'(imem_addr), 32'(k));
        end
        cyc();
        at_neg();
        check("halted_after_wfi", 32'(halted), 32'd1);
        check("oe_after_wfi", 32'(imem_oe), 32'd0);
        drain("drain_stream");

        // Backpressure from reset.
        rst_n     = 1'b0;
        out_ready = 1'b0;
        cyc();
        rst_n = 1'b1;
        at_neg();
        check("bp_oe_c0", 32'(imem_oe), 32'd1);
        cyc();
        at_neg();
        check("bp_oe_c1", 32'(imem_oe), 32'd1);
        check("bp_valid_c1", 32'(out_valid), 32'd1);
        cyc();
        at_neg();
        check("bp_oe_c2", 32'(imem_oe), 32'd0);
        check("bp_addr_c2", 32'(imem_addr), 32'd2);
        check("bp_pc_c2", out_pc, 32'h0);
        cyc();
        at_neg();
        check("bp_oe_c3", 32'(imem_oe), 32'd0);
        check("bp_pc_c3", out_pc, 32'h0);
        check("bp_instr_c3", out_instr, 32'h000000B3);
        cyc();
        out_ready = 1'b1;
        expect_range(32'h0, 32'h8);
        at_neg();
        check("bp_valid_c4", 32'(out_valid), 32'd1);
        cyc();
        at_neg();
        check("bp_valid_c5", 32'(out_valid), 32'd1);
        cyc();
        at_neg();
        check("bp_valid_c6", 32'(out_valid), 32'd1);
        cyc();
        out_ready = 1'b0;
        at_neg();
        check("full_oe", 32'(imem_oe), 32'd0);
        check("full_head", out_pc, 32'hC);
        check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Redirect with a full FIFO; low address bits are dropped.
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h13;
        at_neg();
        check("redir_cycle_oe", 32'(imem_oe), 32'd0);
        cyc();
        redirect_valid = 1'b0;
        at_neg();
        check("redir_valid_n1", 32'(out_valid), 32'd0);
        check("redir_addr_n1", 32'(imem_addr), 32'd4);
        check("redir_oe_n1", 32'(imem_oe), 32'd1);
        cyc();
        at_neg();
        check("redir_valid_n2", 32'(out_valid), 32'd1);
        check("redir_pc_n2", out_pc, 32'h10);
        cyc();
        out_ready = 1'b1;
        expect_range(32'h10, 32'h20);
        drain("drain_redirect");
        at_neg();
        check("halted_after_redirect_stream", 32'(halted), 32'd1);

        // Redirect out of HALT.
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h4;
        at_neg();
        check("halted_in_redirect_cycle", 32'(halted), 32'd1);
        cyc();
        redirect_valid = 1'b0;
        expect_range(32'h4, 32'h20);
        at_neg();
        check("resume_halted", 32'(halted), 32'd0);
        check("resume_oe", 32'(imem_oe), 32'd1);
        check("resume_addr", 32'(imem_addr), 32'd1);
        drain("drain_resume");
        at_neg();
        check("halted_after_resume", 32'(halted), 32'd1);

        // Out-of-range redirect: no ROM access, wfi pushed, halt.
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        cyc();
        redirect_valid = 1'b0;
        begin
            exp_t e;
            e.pc    = 32'h80;
            e.instr = WFI;
            exp_q.push_back(e);
        end
        at_neg();
        check("oor_oe", 32'(imem_oe), 32'd0);
        check("oor_valid_n1", 32'(out_valid), 32'd0);
        check("oor_halted_n1", 32'(halted), 32'd0);
        cyc();
        at_neg();
        check("oor_valid_n2", 32'(out_valid), 32'd1);
        check("oor_halted_n2", 32'(halted), 32'd1);
        drain("drain_oor");

        // Reset mid-stream with a full FIFO.
        cyc();
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        cyc();
        redirect_valid = 1'b0;
        cyc();
        cyc();
        at_neg();
        check("pre_reset_full_valid", 32'(out_valid), 32'd1);
        check("pre_reset_full_oe", 32'(imem_oe), 32'd0);
        cyc();
        rst_n = 1'b0;
        at_neg();
        check("mid_reset_oe", 32'(imem_oe), 32'd0);
        cyc();
        rst_n = 1'b1;
        at_neg();
        check("post_reset_valid", 32'(out_valid), 32'd0);
        check("post_reset_halted", 32'(halted), 32'd0);
        check("post_reset_oe", 32'(imem_oe), 32'd1);
        check("post_reset_addr", 32'(imem_addr), 32'd0);
        cyc();
        out_ready = 1'b1;
        expect_range(32'h0, 32'h20);
        drain("drain_restart");
        at_neg();
        check("halted_after_restart", 32'(halted), 32'd1);

        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit for the single-cycle/multicycle RISC-V datapath. It is the reader side of the instruction ROM: it drives the ROM word address and output enable and captures the returned instruction word. Each instruction is buffered with its PC in a small prefetch FIFO and presented to decode through a valid/ready handshake. It supports branch/jump redirects and stops fetching after a `wfi` is fetched.

## Interface
- `L`, 32: ROM depth in 32-bit words; matches the ROM's `L`.
- `DEPTH`, 2: prefetch FIFO entries (power of two, ≥2).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `imem_addr` output $clog2(L): ROM word address, equal to `pc[$clog2(L)+1:2]`.
- `imem_oe` output 1: ROM output enable; high only on fetch cycles.
- `imem_data` input 32: ROM read data, combinationally valid in the same cycle as `imem_addr`/`imem_oe`.
- `redirect_valid` input 1: load a new PC and flush the FIFO.
- `redirect_pc` input 32: target byte address; bits [1:0] ignored (treated as 0).
- `out_valid` output 1: FIFO head is valid.
- `out_ready` input 1: decode accepts the head.
- `out_instr` output 32: instruction at the head.
- `out_pc` output 32: byte PC of `out_instr`.
- `halted` output 1: fetch is stopped after a `wfi`.

## Operation
- State machine with states RUN and HALT.
- Registers: `pc` (32 bits), FIFO entries of {pc, instr}, and `count` (0..DEPTH).
- Pop: `pop = out_valid & out_ready`.
- Fetch in a cycle when all of these hold: state is RUN, `redirect_valid` is 0, and (`count` < DEPTH or `pop`).
  - On a fetch, push {pc, instr} and set `pc <= pc + 4`.
  - `imem_oe` is 1 only on in-range fetch cycles; otherwise it is 0 and `imem_addr` holds the current `pc` word.
- In-range test: `pc[31:$clog2(L)+2] == 0`. An out-of-range fetch does not access the ROM (`imem_oe` = 0) and pushes `WFI` (32'h10500073) as the instruction.
- If the pushed instruction equals `WFI`, the next state is HALT.
  - HALT: no fetches; the FIFO keeps draining normally.
- Redirect has priority over everything else:
  - FIFO is flushed (`count <= 0`).
  - `pc <= {redirect_pc[31:2], 2'b00}`.
  - State goes to RUN.
  - No fetch occurs in the redirect cycle.
  - A `pop` in the same cycle still counts as accepted by decode.
- Push and pop in the same cycle at full or empty are legal; `count` is unchanged.
- PC arithmetic is modulo 2^32. Wrap from 32'hFFFFFFFC goes to 0, which is in range.
- FIFO order is strict: `out_pc` values between redirects increase by 4.

## Timing
- Reset values (cycle after an edge with `rst_n`=0):
  - `pc`=0, `count`=0, state RUN.
  - `out_valid`=0, `halted`=0.
  - `imem_oe`=0 while `rst_n`=0.
- Latency: an instruction fetched in cycle N is presented with `out_valid`=1 in cycle N+1.
- After reset deasserts, the first fetch (pc 0) is in the first cycle, and `out_valid` rises in the second cycle.
- Throughput: one instruction per cycle with `out_ready` held at 1.
- Backpressure: with `out_ready`=0, fetching stops after DEPTH pushes. `out_instr`/`out_pc` stay stable while `out_valid`=1 and not popped.
- `halted` is registered: 1 in the cycle after the `WFI` push; it returns to 0 in the cycle after a redirect.
- Redirect in cycle N: `out_valid`=0 in N+1, fetch of the target in N+1, and the target is presented in N+2.
- Reset mid-operation takes effect at the next edge regardless of FIFO contents or state; there is no partial flush.

## Structure
- Package `fetch_pkg`:
  - `WFI` constant 32'h10500073.
  - `fetch_state_t` enum {RUN, HALT}.
  - `NOP` constant 32'h00000013.
- Sub-module `fetch_fifo`: synchronous FIFO (parameters `DEPTH`, width 64), with push, pop, flush, count/full/empty, and a head output readable without a pop.
- `instr_fetch` contains the PC register, the FSM, the fetch-enable logic and the range check.

## Test plan
ROM loaded with an 8-word program (word 0 = 32'h000000B3, `add x1,x0,x0`), with `WFI` filling words 8..31; `L`=32, `DEPTH`=2.
- Reset, then `out_ready`=1 → `out_pc` sequence 0x0,0x4,…,0x1C,0x20; `out_instr` at 0x0 = 32'h000000B3 and at 0x20 = 32'h10500073; `halted`=1 and `imem_oe`=0 in the cycle after the 0x20 fetch.
- `out_ready`=0 from reset → exactly 2 cycles with `imem_oe`=1, then `imem_oe`=0 with `pc`=0x8 and `out_pc`=0x0 held stable; raise `out_ready` → 0x0,0x4,0x8 in order with no gaps.
- FIFO full, `redirect_valid`=1 with `redirect_pc`=0x13 → next cycle `out_valid`=0 and `imem_addr`=4; the following cycle `out_pc`=0x10.
- In HALT, redirect to 0x4 → `halted`=0 one cycle later and fetching resumes at 0x4.
- Redirect to 0x80 → `imem_oe` stays 0; `out_pc`=0x80, `out_instr`=32'h10500073, then `halted`=1.
- `rst_n`=0 for one cycle mid-stream with the FIFO full → next cycle `out_valid`=0 and `halted`=0; the stream restarts at `out_pc`=0x0.
